// File: rtl/conv3x3_filter_pkg.sv
// conv_pkg: shared widths, config addresses and reset defaults for the
// conv3x3_filter pipeline and its saturation helper.
//   COEF_W          signed kernel coefficient width
//   PROD_W/ROW_W/SUM_W  product, row-sum and full-sum widths (17/19/21)
//   CFG_ADDR_SHIFT  config address of the normalising shift register
//   identity_coef() reset kernel: centre tap 1, all others 0
package conv_pkg;
   localparam int COEF_W     = 8;
   localparam int N_TAPS     = 9;
   localparam int CENTRE_TAP = 4;
   // {1'b0,pixel} is 9 bits signed; each adder level grows by 2 bits
   localparam int PROD_W     = COEF_W + 9;
   localparam int ROW_W      = PROD_W + 2;
   localparam int SUM_W      = ROW_W + 2;

   localparam logic [3:0] CFG_ADDR_SHIFT = 4'd9;
   localparam logic [3:0] SHIFT_RESET    = 4'd0;

   function automatic logic signed [COEF_W-1:0] identity_coef(input int tap);
      return (tap == CENTRE_TAP) ? COEF_W'(1) : '0;
   endfunction
endpackage

// File: rtl/conv3x3_filter_sat.sv
// conv_sat_u8: combinational arithmetic right shift of the full kernel sum
// followed by a clamp to the unsigned 8-bit pixel range.
//   sum   in  SUM_W signed  full 3x3 sum
//   shift in  4             arithmetic right shift amount
//   pixel out 8             clamped result, 0..255
module conv_sat_u8
   import conv_pkg::*;
(
   input  logic signed [SUM_W-1:0] sum,
   input  logic        [3:0]       shift,
   output logic        [7:0]       pixel
);

   logic signed [SUM_W-1:0] shifted;

   always_comb begin
      shifted = sum >>> shift;
      if (shifted[SUM_W-1]) begin
         pixel = 8'd0;
      end else if (shifted > SUM_W'(255)) begin
         pixel = 8'hFF;
      end else begin
         pixel = shifted[7:0];
      end
   end

endmodule

// File: rtl/conv3x3_filter.sv
// conv3x3_filter: three-stage pipelined 3x3 convolution with loadable signed
// kernel, shift normalisation, 8-bit saturation and a frame pixel counter.
//   clk, rst_n        clock, asynchronous active-low reset
//   start             synchronous frame restart (flush S2/S3, clear counter)
//   in_valid, p1..p9  window handshake and pixels (row-major, p5 centre)
//   cfg_we/addr/data  kernel (addr 0..8) and shift (addr 9) writes
//   out_valid         pixel_out valid, exactly 3 cycles after in_valid
//   pixel_out         filtered pixel, holds when out_valid=0
//   frame_done        one-cycle pulse with the last pixel of a frame
//   busy              any pipeline stage holds valid data
// Handshake: valid-only, no backpressure; every in_valid cycle is accepted
// and produces one out_valid three cycles later unless start intervenes.
module conv3x3_filter
   import conv_pkg::*;
#(
   parameter int FRAME_PIXELS = 65536,
   parameter int CNT_W        = 17
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        p1,
   input  logic [7:0]        p2,
   input  logic [7:0]        p3,
   input  logic [7:0]        p4,
   input  logic [7:0]        p5,
   input  logic [7:0]        p6,
   input  logic [7:0]        p7,
   input  logic [7:0]        p8,
   input  logic [7:0]        p9,
   input  logic              cfg_we,
   input  logic [3:0]        cfg_addr,
   input  logic [COEF_W-1:0] cfg_data,
   output logic              out_valid,
   output logic [7:0]        pixel_out,
   output logic              frame_done,
   output logic              busy
);

   localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(FRAME_PIXELS - 1);

   logic        [7:0]        pix   [N_TAPS];
   logic signed [COEF_W-1:0] coef  [N_TAPS];
   logic        [3:0]        shift;
   logic signed [PROD_W-1:0] prod  [N_TAPS];
   logic signed [ROW_W-1:0]  row   [3];
   logic signed [SUM_W-1:0]  total;
   logic        [7:0]        sat_pixel;
   logic                     s1_valid;
   logic                     s2_valid;
   logic        [CNT_W-1:0]  pix_cnt;

   assign pix[0] = p1;
   assign pix[1] = p2;
   assign pix[2] = p3;
   assign pix[3] = p4;
   assign pix[4] = p5;
   assign pix[5] = p6;
   assign pix[6] = p7;
   assign pix[7] = p8;
   assign pix[8] = p9;

   // Configuration registers; addresses 10..15 fall through untouched.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_TAPS; i++) coef[i] <= identity_coef(i);
         shift <= SHIFT_RESET;
      end else if (cfg_we) begin
         for (int i = 0; i < N_TAPS; i++) begin
            if (cfg_addr == 4'(i)) coef[i] <= cfg_data;
         end
         if (cfg_addr == CFG_ADDR_SHIFT) shift <= cfg_data[3:0];
      end
   end

   // S1: products. A start does not block the window arriving with it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         for (int i = 0; i < N_TAPS; i++) prod[i] <= '0;
      end else begin
         s1_valid <= in_valid;
         if (in_valid) begin
            for (int i = 0; i < N_TAPS; i++)
               prod[i] <= PROD_W'(signed'({1'b0, pix[i]})) * PROD_W'(coef[i]);
         end
      end
   end

   // S2: row sums. The window leaving S1 while start is high is discarded.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         for (int r = 0; r < 3; r++) row[r] <= '0;
      end else begin
         s2_valid <= s1_valid && !start;
         if (s1_valid) begin
            for (int r = 0; r < 3; r++)
               row[r] <= ROW_W'(prod[3*r]) + ROW_W'(prod[3*r+1]) + ROW_W'(prod[3*r+2]);
         end
      end
   end

   assign total = SUM_W'(row[0]) + SUM_W'(row[1]) + SUM_W'(row[2]);

   // The shift register is sampled here, so it applies at the S2->S3 edge.
   conv_sat_u8 u_sat (
      .sum   (total),
      .shift (shift),
      .pixel (sat_pixel)
   );

   // S3: output register and frame counter; start wins over frame_done.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         pixel_out  <= 8'd0;
         frame_done <= 1'b0;
         pix_cnt    <= '0;
      end else if (start) begin
         out_valid  <= 1'b0;
         frame_done <= 1'b0;
         pix_cnt    <= '0;
      end else begin
         out_valid  <= s2_valid;
         frame_done <= 1'b0;
         if (s2_valid) begin
            pixel_out <= sat_pixel;
            if (pix_cnt == LAST_PIX) begin
               frame_done <= 1'b1;
               pix_cnt    <= '0;
            end else begin
               pix_cnt <= pix_cnt + CNT_W'(1);
            end
         end
      end
   end

   assign busy = s1_valid | s2_valid | out_valid;

endmodule

// File: tb/tb_conv3x3_filter.sv
// tb_conv3x3_filter: directed-vector bench for conv3x3_filter with a small
// frame (16 pixels). Drivers push {due_cycle, frame_done, pixel} into a
// scoreboard queue; a negedge monitor pops and compares on each out_valid.
module tb_conv3x3_filter;
   import conv_pkg::*;

   localparam int FP = 16;
   localparam int EW = 25;

   logic              clk;
   logic              rst_n;
   logic              start;
   logic              in_valid;
   logic [7:0]        p1, p2, p3, p4, p5, p6, p7, p8, p9;
   logic              cfg_we;
   logic [3:0]        cfg_addr;
   logic [COEF_W-1:0] cfg_data;
   logic              out_valid;
   logic [7:0]        pixel_out;
   logic              frame_done;
   logic              busy;

   logic [EW-1:0] exp_q[$];
   logic [EW-1:0] mon_e;
   int            n_vec;
   int            n_err;
   int            cyc;
   int            model_cnt;
   bit            mon_en;

   conv3x3_filter #(.FRAME_PIXELS(FP), .CNT_W(5)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .in_valid   (in_valid),
      .p1         (p1),
      .p2         (p2),
      .p3         (p3),
      .p4         (p4),
      .p5         (p5),
      .p6         (p6),
      .p7         (p7),
      .p8         (p8),
      .p9         (p9),
      .cfg_we     (cfg_we),
      .cfg_addr   (cfg_addr),
      .cfg_data   (cfg_data),
      .out_valid  (out_valid),
      .pixel_out  (pixel_out),
      .frame_done (frame_done),
      .busy       (busy)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- driver tasks ----------------
   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d", name, act, req);
      end
   endtask

   task automatic push_exp(input logic [7:0] px);
      logic fd;
      fd = (model_cnt == FP - 1);
      model_cnt = fd ? 0 : model_cnt + 1;
      exp_q.push_back({16'(cyc + 3), fd, px});
   endtask

   task automatic drive_win(input logic [7:0] w [9], input logic [7:0] px,
                            input bit keep, input bit st);
      in_valid = 1'b1;
      p1 = w[0]; p2 = w[1]; p3 = w[2];
      p4 = w[3]; p5 = w[4]; p6 = w[5];
      p7 = w[6]; p8 = w[7]; p9 = w[8];
      start = st;
      if (st) model_cnt = 0;
      if (keep) push_exp(px);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      start    = 1'b0;
   endtask

   task automatic drive_co(input logic [7:0] centre, input logic [7:0] others,
                           input logic [7:0] px, input bit keep, input bit st);
      logic [7:0] w [9];
      for (int i = 0; i < 9; i++) w[i] = (i == 4) ? centre : others;
      drive_win(w, px, keep, st);
   endtask

   task automatic cfg_write(input logic [3:0] addr, input logic [7:0] data);
      cfg_we   = 1'b1;
      cfg_addr = addr;
      cfg_data = data;
      @(posedge clk);
      #1;
      cfg_we = 1'b0;
   endtask

   task automatic load_kernel(input logic [7:0] k [9], input logic [3:0] sh);
      for (int i = 0; i < 9; i++) cfg_write(4'(i), k[i]);
      cfg_write(CFG_ADDR_SHIFT, {4'd0, sh});
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      if (rst_n && mon_en) begin
         n_vec++;
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_out: pixel=%0d fd=%0b at cycle %0d, want no output",
                        pixel_out, frame_done, cyc);
            end else begin
               mon_e = exp_q.pop_front();
               if ({16'(cyc), frame_done, pixel_out} !== mon_e) begin
                  n_err++;
                  $display("FAIL out_pixel: got pixel=%0d fd=%0b cycle=%0d, want pixel=%0d fd=%0b cycle=%0d",
                           pixel_out, frame_done, cyc[15:0], mon_e[7:0], mon_e[8], mon_e[24:9]);
               end
            end
         end else if (frame_done) begin
            n_err++;
            $display("FAIL stray_frame_done: got 1 with out_valid=0 at cycle %0d, want 0", cyc);
         end
      end
   end

   // ---------------- stimulus ----------------
   logic [7:0] win   [9];
   logic [7:0] k_box [9];
   logic [7:0] k_lap [9];
   logic [7:0] k_id  [9];

   initial begin
      n_vec = 0; n_err = 0; cyc = 0; model_cnt = 0; mon_en = 0;
      rst_n = 1'b0; start = 1'b0; in_valid = 1'b0;
      p1 = 0; p2 = 0; p3 = 0; p4 = 0; p5 = 0; p6 = 0; p7 = 0; p8 = 0; p9 = 0;
      cfg_we = 1'b0; cfg_addr = 4'd0; cfg_data = 8'd0;
      win   = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
      k_box = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
      k_lap = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'd8, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
      k_id  = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0};

      idle(3);
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_pixel_out", 32'(pixel_out), 0);
      check("rst_frame_done", 32'(frame_done), 0);
      check("rst_busy", 32'(busy), 0);
      rst_n  = 1'b1;
      mon_en = 1'b1;
      idle(2);

      // Identity kernel from reset: output = p5
      repeat (5) drive_win(win, 8'd5, 1'b1, 1'b0);
      check("busy_active", 32'(busy), 1);
      idle(5);

      // Box kernel, shift 3
      load_kernel(k_box, 4'd3);
      drive_co(8'd80, 8'd80, 8'd90, 1'b1, 1'b0);
      drive_co(8'd255, 8'd255, 8'd255, 1'b1, 1'b0);
      idle(5);

      // Laplacian kernel, shift 0
      load_kernel(k_lap, 4'd0);
      drive_co(8'd255, 8'd0, 8'd255, 1'b1, 1'b0);
      drive_co(8'd0, 8'd255, 8'd0, 1'b1, 1'b0);
      drive_co(8'd100, 8'd100, 8'd0, 1'b1, 1'b0);
      drive_co(8'd50, 8'd40, 8'd80, 1'b1, 1'b0);
      idle(5);

      // Frame counter: restart then 32 continuous windows
      load_kernel(k_id, 4'd0);
      start = 1'b1;
      model_cnt = 0;
      idle(1);
      start = 1'b0;
      idle(3);
      for (int k = 0; k < 32; k++) drive_co(8'(k), 8'd0, 8'(k), 1'b1, 1'b0);
      idle(5);

      // Start with two windows in flight plus a new window alongside it
      drive_co(8'd200, 8'd0, 8'd0, 1'b0, 1'b0);
      drive_co(8'd201, 8'd0, 8'd0, 1'b0, 1'b0);
      drive_co(8'd7, 8'd0, 8'd7, 1'b1, 1'b1);
      for (int k = 1; k < 16; k++) drive_co(8'(k + 10), 8'd0, 8'(k + 10), 1'b1, 1'b0);
      idle(5);

      // Coefficient write between back-to-back windows; ignored addresses
      cfg_we = 1'b1; cfg_addr = 4'd4; cfg_data = 8'd2;
      drive_co(8'd10, 8'd0, 8'd10, 1'b1, 1'b0);
      cfg_we = 1'b0;
      drive_co(8'd10, 8'd0, 8'd20, 1'b1, 1'b0);
      cfg_we = 1'b1; cfg_addr = 4'd12; cfg_data = 8'd5;
      drive_co(8'd10, 8'd0, 8'd20, 1'b1, 1'b0);
      cfg_addr = 4'd15; cfg_data = 8'd0;
      drive_co(8'd10, 8'd0, 8'd20, 1'b1, 1'b0);
      cfg_we = 1'b0;
      drive_co(8'd10, 8'd0, 8'd20, 1'b1, 1'b0);
      idle(6);

      check("end_busy", 32'(busy), 0);
      check("end_out_valid", 32'(out_valid), 0);
      check("end_queue_empty", 32'(exp_q.size()), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
